// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt arbiter controller.
// Optional build macro IRQ_FIXED_PRIO_EN (used by irq_rr_pick / irq_arbiter_ctrl).
package irq_pkg;

    localparam int          IRQ_MAX        = 16;
    localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_arbiter_ctrl_if.sv
// Peripheral/core-side signal bundle of the interrupt arbiter.
// master = stimulus side (peripherals + core), slave = the controller.
interface irq_arbiter_ctrl_if #(
    parameter int N_IRQ = 16,
    parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);
    logic [N_IRQ-1:0] irq_req_i;
    logic [N_IRQ-1:0] irq_mask_i;
    logic             irq_ret_i;
    logic             irq_o;
    logic [31:0]      irq_cause_o;
    logic [ID_W-1:0]  irq_id_o;
    logic [N_IRQ-1:0] irq_fin_o;
    logic             busy_o;

    modport master (
        output irq_req_i, irq_mask_i, irq_ret_i,
        input  irq_o, irq_cause_o, irq_id_o, irq_fin_o, busy_o
    );

    modport slave (
        input  irq_req_i, irq_mask_i, irq_ret_i,
        output irq_o, irq_cause_o, irq_id_o, irq_fin_o, busy_o
    );
endinterface

// File: rtl/irq_rr_pick.sv
// Combinational winner search over the masked pending vector.
// IRQ_FIXED_PRIO_EN selects lowest-index priority; otherwise rotate from ptr.
module irq_rr_pick #(
    parameter int N_IRQ = 16,
    parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] pend,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  winner
);

`ifdef IRQ_FIXED_PRIO_EN
    // Scan from the top so the lowest pending index is written last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
    end
`else
    int idx_i;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx_i  = 0;
        for (int k = 0; k < N_IRQ; k++) begin
            idx_i = int'(ptr) + k;
            if (idx_i >= N_IRQ) idx_i = idx_i - N_IRQ;
            if (!found && pend[ID_W'(idx_i)]) begin
                found  = 1'b1;
                winner = ID_W'(idx_i);
            end
        end
    end
`endif

endmodule

// File: rtl/irq_arbiter_ctrl.sv
// Interrupt arbiter: masks level requests, grants one source to the core and
// returns a fin pulse on mret. IRQ_FIXED_PRIO_EN drops the round-robin pointer.
//
// state | meaning
// IDLE  | waiting for any masked request; winner latched on exit
// BUSY  | trap outstanding at the core, id_q frozen until irq_ret_i
// FIN   | one-cycle completion pulse to the granted source
module irq_arbiter_ctrl
    import irq_pkg::*;
#(
    parameter int N_IRQ = 16,
    parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    irq_arbiter_ctrl_if.slave bus
);

    if (N_IRQ < 1 || N_IRQ > IRQ_MAX) begin : g_bad_n
        $error("N_IRQ out of range");
    end

    irq_state_t       state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_cur;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic [N_IRQ-1:0] pend;

    assign pend = bus.irq_req_i & bus.irq_mask_i;

`ifdef IRQ_FIXED_PRIO_EN
    assign ptr_cur = '0;
`else
    logic [ID_W-1:0] ptr_q, ptr_d;
    assign ptr_cur = ptr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && found)
            ptr_d = (winner == ID_W'(N_IRQ - 1)) ? '0 : winner + 1'b1;
    end
`endif

    irq_rr_pick #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_pick (
        .pend   (pend),
        .ptr    (ptr_cur),
        .found  (found),
        .winner (winner)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // pend is only looked at in IDLE, so a source high during FIN cannot re-win early.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = BUSY;
                id_d    = winner;
            end
            BUSY: if (bus.irq_ret_i) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.irq_o       = (state_q == BUSY);
        bus.busy_o      = (state_q == BUSY);
        bus.irq_cause_o = (state_q == BUSY) ? IRQ_CAUSE_BASE + 32'(id_q) : 32'h0;
        bus.irq_id_o    = (state_q == BUSY || state_q == FIN) ? id_q : '0;
        bus.irq_fin_o   = '0;
        for (int i = 0; i < N_IRQ; i++)
            bus.irq_fin_o[i] = (state_q == FIN) && (id_q == ID_W'(i));
    end

endmodule

// File: doc/irq_arbiter_ctrl.md
# irq_arbiter_ctrl

Interrupt controller between the system-bus peripherals and the core's single interrupt input. It collects level interrupt requests from up to 16 peripherals (UART RX, timer, switches, ...), masks them, arbitrates one winner and drives `irq_req_i` and the cause value of `riscv_core`. It tracks the trap until the core's `irq_ret_o` and then returns a one-cycle completion pulse to the granted peripheral's `interrupt_return_i`.

## Interface
- `N_IRQ`, 16 — number of request lines; legal range 1..16.
- `ID_W`, `$clog2(N_IRQ)` (min 1) — width of the source index.
- `clk_i`  in  1  — system clock (`sysclk`).
- `rst_n_i`  in  1  — **one clock; reset is asynchronous and active-low**.
- `irq_req_i`  in  N_IRQ  — level requests from peripherals; bit i = source i.
- `irq_mask_i`  in  N_IRQ  — per-source enable (mie image); 1 = enabled.
- `irq_ret_i`  in  1  — one-cycle pulse from core on `mret`.
- `irq_o`  out  1  — interrupt request to core.
- `irq_cause_o`  out  32  — mcause value for the granted source.
- `irq_id_o`  out  ID_W  — index of the granted source.
- `irq_fin_o`  out  N_IRQ  — one-hot completion pulse to the granted source.
- `busy_o`  out  1  — high from grant until completion.

## Operation
- Masked pending vector: `pend = irq_req_i & irq_mask_i`.
- FSM states:
  - `IDLE`: if `pend != 0`, latch the winner into `id_q`, go to `BUSY`.
  - `BUSY`: hold `id_q`. On `irq_ret_i`, go to `FIN`.
  - `FIN`: assert `irq_fin_o[id_q]`, go to `IDLE`.
- Round-robin arbitration (default):
  - Rotating pointer `ptr`.
  - The search starts at `ptr` and runs upward through the indices, wrapping at N_IRQ−1 → 0.
  - On each grant, `ptr <= (winner == N_IRQ-1) ? 0 : winner + 1`.
- `irq_o = busy_o = (state == BUSY)`.
- `irq_cause_o = 32'h8000_0010 + id_q` while `BUSY`, otherwise 0. Interrupt bit 31 is set; codes 16..31 are platform-local.
- `irq_id_o = id_q` in `BUSY`/`FIN`, otherwise 0.
- Boundary behaviour:
  - `irq_ret_i` in `IDLE` or `FIN` is ignored.
  - Changes to `irq_req_i`/`irq_mask_i` during `BUSY` do not change `id_q`. If the granted request drops, the controller stays in `BUSY` until `irq_ret_i`, because the core handles spurious traps.
  - `pend` is not sampled in `FIN`, so a source still high in `FIN` cannot re-win before it sees its fin pulse.
  - All sources pending with `ptr = 0`: grants go 0, 1, 2, … in successive rounds.
  - Reset at any time: state `IDLE`, `ptr` = 0, `id_q` = 0, all outputs 0 on the next edge-free assertion (asynchronous).

## Timing
- Reset values: `irq_o` = 0, `busy_o` = 0, `irq_cause_o` = 0, `irq_id_o` = 0, `irq_fin_o` = 0.
- Grant latency: `pend` nonzero at edge t (in `IDLE`) → `irq_o`, `irq_cause_o` and `irq_id_o` valid after edge t, i.e. in cycle t+1. All outputs are registered or decoded from registered state.
- Completion: `irq_ret_i` sampled at edge r → `irq_o` low and `irq_fin_o[id_q]` high for exactly cycle r+1 → `IDLE` in cycle r+2.
- Earliest next grant: `irq_o` high again in cycle r+3.
- No combinational path from any input to any output.

## Configuration
- `IRQ_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest pending index wins.
  - `ptr` register is not implemented.
- `IRQ_FIXED_PRIO_EN` undefined: round-robin as described above.
- FSM, timing and ports are identical in both modes.

## Structure
- Package `irq_pkg`:
  - `irq_state_t` enum (`IDLE`, `BUSY`, `FIN`).
  - `IRQ_CAUSE_BASE = 32'h8000_0010`.
  - `IRQ_MAX = 16`.
- Sub-module `irq_rr_pick`: purely combinational. Inputs are `pend` and `ptr`; outputs are a `found` flag and `winner` index. It contains both the rotating and the fixed-priority search, selected by the macro.
- `irq_arbiter_ctrl` holds the FSM, `id_q`, `ptr` and the output decode.

## Test plan
- Reset with `irq_req_i = 16'hFFFF` and mask all 1 → all outputs 0. After release, `irq_o` = 1 one cycle later with `irq_id_o` = 0 and `irq_cause_o` = 32'h8000_0010.
- Request on source 5 only, mask 16'h0020 → cause 32'h8000_0015. `irq_ret_i` pulse → `irq_fin_o` = 16'h0020 for one cycle, `irq_o` low that cycle, next grant no earlier than 2 cycles later.
- Mask 16'h0000 with `irq_req_i` = 16'hFFFF for 20 cycles → `irq_o` stays 0. Set mask bit 3 → `irq_id_o` = 3.
- Sources 2 and 9 held high with a repeated ret handshake → grants alternate 2, 9, 2, 9 (round-robin). With `IRQ_FIXED_PRIO_EN` → 2, 2, 2.
- In `BUSY` on source 4, drop `irq_req_i[4]` and raise `[1]` → `irq_id_o` stays 4 until ret, then source 1 is granted.
- Assert `rst_n_i` low mid-`BUSY` (async, between edges) → `irq_o`, `busy_o` and `irq_fin_o` go 0 immediately, with no fin pulse after release.
